// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared widths, FSM encoding and helpers for cache_ctrl
// Holds the tag/index/block/enable widths and the controller state encoding
// used by cache_ctrl, cache_stats and anything driving the block RAM.
package cache_ctrl_pkg;

    localparam int TAG_WIDTH        = 18;
    localparam int INDEX_WIDTH      = 10;
    localparam int CACHE_BLOCK_SIZE = 128;
    localparam int EN_WORD_WIDTH    = 4;
    localparam int EN_BYTE_WIDTH    = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_COMPARE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_ALLOCATE  = 3'd4,
        ST_REFILL    = 3'd5
    } cache_state_t;

    // Word-aligned, half-word-aligned and single-byte writes are accepted.
    function automatic logic byte_en_legal(input logic [EN_BYTE_WIDTH-1:0] be);
        case (be)
            4'b1111, 4'b0011, 4'b1100,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: byte_en_legal = 1'b1;
            default:                            byte_en_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [EN_WORD_WIDTH-1:0] word_onehot(input logic [1:0] word);
        word_onehot = 4'b0001 << word;
    endfunction

endpackage

// File: rtl/cache_stats.sv
// rtl/cache_stats.sv - saturating first-pass hit/miss counters for cache_ctrl
// Ports: clk, rst_n (async active-low), hit_pulse/miss_pulse (one per lookup),
//        hit_cnt/miss_cnt (32-bit saturating counts).
module cache_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hit_pulse,
    input  logic        miss_pulse,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            if (hit_pulse && (hit_cnt != 32'hFFFF_FFFF))
                hit_cnt <= hit_cnt + 32'd1;
            if (miss_pulse && (miss_cnt != 32'hFFFF_FFFF))
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped write-back write-allocate cache controller
// Ports: clk, rst_n (async active-low);
//        CPU side  CPU_Req/CPU_Wr/CPU_Addr/CPU_Byte_En/CPU_Wdata in, CPU_Rdata/CPU_Rdy out;
//        memory    Mem_Req/Mem_Wr/Mem_Addr/Mem_Wdata out, Mem_Rdata/Mem_Ack in;
//        block RAM En_Word/En_Byte/Index/Wr/ValidNew/DirtyNew/Data_In/Tag_In out,
//                  Dirty_Out/Valid_Out/Tag_Out/Data_Out in (one-cycle read latency).
// Optional: CACHE_CTRL_STATS_EN adds Hit_Cnt/Miss_Cnt outputs via cache_stats.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = INDEX_WIDTH,
    parameter int TAG_W   = TAG_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        CPU_Req,
    input  logic                        CPU_Wr,
    input  logic [ADDR_W-1:0]           CPU_Addr,
    input  logic [EN_BYTE_WIDTH-1:0]    CPU_Byte_En,
    input  logic [31:0]                 CPU_Wdata,
    output logic [31:0]                 CPU_Rdata,
    output logic                        CPU_Rdy,
    output logic                        Mem_Req,
    output logic                        Mem_Wr,
    output logic [ADDR_W-1:0]           Mem_Addr,
    output logic [CACHE_BLOCK_SIZE-1:0] Mem_Wdata,
    input  logic [CACHE_BLOCK_SIZE-1:0] Mem_Rdata,
    input  logic                        Mem_Ack,
    output logic [EN_WORD_WIDTH-1:0]    En_Word,
    output logic [EN_BYTE_WIDTH-1:0]    En_Byte,
    output logic [INDEX_W-1:0]          Index,
    output logic                        Wr,
    output logic                        ValidNew,
    output logic                        DirtyNew,
    output logic [CACHE_BLOCK_SIZE-1:0] Data_In,
    output logic [TAG_W-1:0]            Tag_In,
    input  logic                        Dirty_Out,
    input  logic                        Valid_Out,
    input  logic [TAG_W-1:0]            Tag_Out,
    input  logic [CACHE_BLOCK_SIZE-1:0] Data_Out
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]                 Hit_Cnt,
    output logic [31:0]                 Miss_Cnt
`endif
);

    cache_state_t                  state;
    logic                          req_wr;
    logic [TAG_W-1:0]              req_tag;
    logic [INDEX_W-1:0]            req_index;
    logic [1:0]                    req_word;
    logic [EN_BYTE_WIDTH-1:0]      req_be;
    logic [31:0]                   req_wdata;
    logic [CACHE_BLOCK_SIZE-1:0]   fill_data;
    logic                          hit;
    logic                          unused_addr_bits;

    // Byte offset within the word is not needed: the CPU port is word-wide.
    assign unused_addr_bits = ^CPU_Addr[1:0];

    assign hit = Valid_Out && (Tag_Out == req_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_wr    <= 1'b0;
            req_tag   <= '0;
            req_index <= '0;
            req_word  <= 2'd0;
            req_be    <= '0;
            req_wdata <= 32'd0;
            fill_data <= '0;
            Mem_Req   <= 1'b0;
            Mem_Wr    <= 1'b0;
            Mem_Addr  <= '0;
            Mem_Wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (CPU_Req) begin
                        req_wr    <= CPU_Wr;
                        req_tag   <= CPU_Addr[ADDR_W-1 -: TAG_W];
                        req_index <= CPU_Addr[INDEX_W+3:4];
                        req_word  <= CPU_Addr[3:2];
                        req_be    <= CPU_Byte_En;
                        req_wdata <= CPU_Wdata;
                        state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: state <= ST_COMPARE;
                ST_COMPARE: begin
                    if (hit) begin
                        state <= ST_IDLE;
                    end else if (Valid_Out && Dirty_Out) begin
                        // Victim line and its address are captured now; the
                        // block output is not held once the index moves on.
                        Mem_Req   <= 1'b1;
                        Mem_Wr    <= 1'b1;
                        Mem_Addr  <= {Tag_Out, req_index, 4'b0000};
                        Mem_Wdata <= Data_Out;
                        state     <= ST_WRITEBACK;
                    end else begin
                        Mem_Req  <= 1'b1;
                        Mem_Wr   <= 1'b0;
                        Mem_Addr <= {req_tag, req_index, 4'b0000};
                        state    <= ST_ALLOCATE;
                    end
                end
                ST_WRITEBACK: begin
                    if (Mem_Ack) begin
                        Mem_Wr   <= 1'b0;
                        Mem_Addr <= {req_tag, req_index, 4'b0000};
                        state    <= ST_ALLOCATE;
                    end
                end
                ST_ALLOCATE: begin
                    if (Mem_Ack) begin
                        Mem_Req   <= 1'b0;
                        fill_data <= Mem_Rdata;
                        state     <= ST_REFILL;
                    end
                end
                ST_REFILL: state <= ST_LOOKUP;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Block RAM and CPU response decode. The hit decision needs this cycle's
    // block read data, so the COMPARE responses cannot be registered.
    always_comb begin
        CPU_Rdy   = 1'b0;
        CPU_Rdata = 32'd0;
        Wr        = 1'b0;
        En_Word   = '0;
        En_Byte   = '0;
        ValidNew  = 1'b0;
        DirtyNew  = 1'b0;
        Data_In   = '0;
        Tag_In    = '0;
        Index     = (state == ST_IDLE) ? CPU_Addr[INDEX_W+3:4] : req_index;

        if ((state == ST_COMPARE) && hit) begin
            CPU_Rdy = 1'b1;
            if (!req_wr) begin
                CPU_Rdata = Data_Out[{req_word, 5'b00000} +: 32];
            end else if (byte_en_legal(req_be)) begin
                Wr       = 1'b1;
                En_Word  = word_onehot(req_word);
                En_Byte  = req_be;
                Data_In  = {4{req_wdata}};
                ValidNew = 1'b1;
                DirtyNew = 1'b1;
                Tag_In   = req_tag;
            end
        end

        if (state == ST_REFILL) begin
            Wr       = 1'b1;
            En_Word  = '0;          // all-zero word enable means whole-line write
            En_Byte  = 4'b1111;
            Data_In  = fill_data;
            ValidNew = 1'b1;
            DirtyNew = 1'b0;
            Tag_In   = req_tag;
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    // Set by REFILL so the guaranteed-hit retry is not counted as a hit.
    logic retry;
    logic hit_pulse;
    logic miss_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retry <= 1'b0;
        else if (state == ST_IDLE)
            retry <= 1'b0;
        else if (state == ST_REFILL)
            retry <= 1'b1;
    end

    assign hit_pulse  = (state == ST_COMPARE) && !retry && hit;
    assign miss_pulse = (state == ST_COMPARE) && !retry && !hit;

    cache_stats u_stats (
        .clk        (clk),
        .rst_n      (rst_n),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .hit_cnt    (Hit_Cnt),
        .miss_cnt   (Miss_Cnt)
    );
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - scoreboard bench for cache_ctrl with block RAM and memory models
module tb_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         CPU_Req = 1'b0;
    logic         CPU_Wr = 1'b0;
    logic [31:0]  CPU_Addr = 32'd0;
    logic [3:0]   CPU_Byte_En = 4'd0;
    logic [31:0]  CPU_Wdata = 32'd0;
    logic [31:0]  CPU_Rdata;
    logic         CPU_Rdy;
    logic         Mem_Req;
    logic         Mem_Wr;
    logic [31:0]  Mem_Addr;
    logic [127:0] Mem_Wdata;
    logic [127:0] Mem_Rdata = '0;
    logic         Mem_Ack = 1'b0;
    logic [3:0]   En_Word;
    logic [3:0]   En_Byte;
    logic [9:0]   Index;
    logic         Wr;
    logic         ValidNew;
    logic         DirtyNew;
    logic [127:0] Data_In;
    logic [17:0]  Tag_In;
    logic         Dirty_Out = 1'b0;
    logic         Valid_Out = 1'b0;
    logic [17:0]  Tag_Out = '0;
    logic [127:0] Data_Out = '0;
`ifdef CACHE_CTRL_STATS_EN
    logic [31:0]  Hit_Cnt;
    logic [31:0]  Miss_Cnt;
`endif

    cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .CPU_Req(CPU_Req), .CPU_Wr(CPU_Wr), .CPU_Addr(CPU_Addr),
        .CPU_Byte_En(CPU_Byte_En), .CPU_Wdata(CPU_Wdata),
        .CPU_Rdata(CPU_Rdata), .CPU_Rdy(CPU_Rdy),
        .Mem_Req(Mem_Req), .Mem_Wr(Mem_Wr), .Mem_Addr(Mem_Addr),
        .Mem_Wdata(Mem_Wdata), .Mem_Rdata(Mem_Rdata), .Mem_Ack(Mem_Ack),
        .En_Word(En_Word), .En_Byte(En_Byte), .Index(Index), .Wr(Wr),
        .ValidNew(ValidNew), .DirtyNew(DirtyNew), .Data_In(Data_In), .Tag_In(Tag_In),
        .Dirty_Out(Dirty_Out), .Valid_Out(Valid_Out), .Tag_Out(Tag_Out), .Data_Out(Data_Out)
`ifdef CACHE_CTRL_STATS_EN
        , .Hit_Cnt(Hit_Cnt), .Miss_Cnt(Miss_Cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory contents ----------------
    function automatic logic [127:0] mem_init(input logic [27:0] la);
        logic [31:0] s;
        if (la == 28'h100)
            return {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        s = {la, 4'h0};
        return {s ^ 32'h3333_0003, s ^ 32'h2222_0002, s ^ 32'h1111_0001, s ^ 32'h5A5A_0000};
    endfunction

    logic [127:0] mem_store [logic [27:0]];
    logic [127:0] ref_mem   [logic [27:0]];

    // ---------------- reference model ----------------
    typedef struct { logic wr; logic [31:0] addr; logic [127:0] data; } mem_txn_t;
    typedef struct { logic is_read; logic [31:0] data; } cpu_exp_t;
    mem_txn_t mem_exp_q[$];
    cpu_exp_t cpu_exp_q[$];

    logic         ref_valid [1024];
    logic         ref_dirty [1024];
    logic [17:0]  ref_tag   [1024];
    logic [127:0] ref_data  [1024];
    int ref_hits = 0;
    int ref_misses = 0;

    task automatic ref_access(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata);
        logic [9:0]  idx;
        logic [17:0] tag;
        int          w;
        mem_txn_t    t;
        cpu_exp_t    c;
        idx = addr[13:4];
        tag = addr[31:14];
        w   = int'(addr[3:2]);
        if (ref_valid[idx] && ref_tag[idx] == tag) begin
            ref_hits++;
        end else begin
            ref_misses++;
            if (ref_valid[idx] && ref_dirty[idx]) begin
                t.wr = 1'b1; t.addr = {ref_tag[idx], idx, 4'h0}; t.data = ref_data[idx];
                mem_exp_q.push_back(t);
                ref_mem[{ref_tag[idx], idx}] = ref_data[idx];
            end
            t.wr = 1'b0; t.addr = {tag, idx, 4'h0}; t.data = '0;
            mem_exp_q.push_back(t);
            ref_data[idx]  = ref_mem.exists({tag, idx}) ? ref_mem[{tag, idx}] : mem_init({tag, idx});
            ref_valid[idx] = 1'b1;
            ref_dirty[idx] = 1'b0;
            ref_tag[idx]   = tag;
        end
        if (wr) begin
            if (be inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000}) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_data[idx][w*32 + b*8 +: 8] = wdata[b*8 +: 8];
                ref_dirty[idx] = 1'b1;
            end
            c.is_read = 1'b0; c.data = 32'd0;
        end else begin
            c.is_read = 1'b1; c.data = ref_data[idx][w*32 +: 32];
        end
        cpu_exp_q.push_back(c);
    endtask

    // ---------------- block RAM model (one-cycle read) ----------------
    logic         blk_valid [1024];
    logic         blk_dirty [1024];
    logic [17:0]  blk_tag   [1024];
    logic [127:0] blk_data  [1024];

    initial begin : block_ram
        logic [9:0]   s_idx;
        logic         s_wr, s_v, s_d;
        logic [3:0]   s_ew, s_eb;
        logic [127:0] s_din;
        logic [17:0]  s_tag;
        forever begin
            @(negedge clk);
            s_idx = Index; s_wr = Wr; s_ew = En_Word; s_eb = En_Byte;
            s_din = Data_In; s_v = ValidNew; s_d = DirtyNew; s_tag = Tag_In;
            @(posedge clk);
            #1;
            if (s_wr && rst_n) begin
                if (s_ew == 4'b0000) begin
                    blk_data[s_idx] = s_din;
                end else begin
                    for (int w = 0; w < 4; w++)
                        if (s_ew[w])
                            for (int b = 0; b < 4; b++)
                                if (s_eb[b]) blk_data[s_idx][w*32 + b*8 +: 8] = s_din[w*32 + b*8 +: 8];
                end
                blk_valid[s_idx] = s_v;
                blk_dirty[s_idx] = s_d;
                blk_tag[s_idx]   = s_tag;
            end
            Valid_Out = blk_valid[s_idx];
            Dirty_Out = blk_dirty[s_idx];
            Tag_Out   = blk_tag[s_idx];
            Data_Out  = blk_data[s_idx];
        end
    end

    // ---------------- memory model with transaction checking ----------------
    logic mem_hold = 1'b0;

    initial begin : mem_model
        int       wait_n;
        mem_txn_t e;
        wait_n = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                Mem_Ack = 1'b0;
                wait_n  = 0;
            end else if (Mem_Ack) begin
                Mem_Ack = 1'b0;
            end else if (Mem_Req && !mem_hold) begin
                if (wait_n > 0) begin
                    wait_n--;
                end else begin
                    if (mem_exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL mem_unexpected: got wr=%0b addr=%0h expected no transaction", Mem_Wr, Mem_Addr);
                    end else begin
                        e = mem_exp_q.pop_front();
                        check("mem_wr", {127'd0, Mem_Wr}, {127'd0, e.wr});
                        check("mem_addr", {96'd0, Mem_Addr}, {96'd0, e.addr});
                        if (e.wr) check("mem_wdata", Mem_Wdata, e.data);
                    end
                    if (Mem_Wr)
                        mem_store[Mem_Addr[31:4]] = Mem_Wdata;
                    else
                        Mem_Rdata = mem_store.exists(Mem_Addr[31:4]) ? mem_store[Mem_Addr[31:4]]
                                                                     : mem_init(Mem_Addr[31:4]);
                    Mem_Ack = 1'b1;
                    wait_n  = $urandom_range(0, 3);
                end
            end
        end
    end

    // ---------------- CPU response monitor ----------------
    initial begin : cpu_monitor
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && CPU_Rdy) begin
                if (cpu_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cpu_unexpected_rdy: got rdy=1 expected no response");
                end else begin
                    e = cpu_exp_q.pop_front();
                    if (e.is_read) check("cpu_rdata", {96'd0, CPU_Rdata}, {96'd0, e.data});
                end
            end
        end
    end

    // ---------------- CPU driver ----------------
    logic [31:0] last_rdata;
    logic        last_wr;
    logic [3:0]  last_ew;
    logic        last_dn;

    task automatic cpu_op(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, output int lat, output int mreq);
        ref_access(wr, addr, be, wdata);
        @(negedge clk);
        CPU_Req = 1'b1; CPU_Wr = wr; CPU_Addr = addr; CPU_Byte_En = be; CPU_Wdata = wdata;
        lat = 0; mreq = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (Mem_Req) mreq++;
            if (CPU_Rdy) break;
            if (lat > 200) begin
                checks++; errors++;
                $display("FAIL cpu_timeout: got no CPU_Rdy within 200 cycles for addr %0h", addr);
                break;
            end
        end
        last_rdata = CPU_Rdata; last_wr = Wr; last_ew = En_Word; last_dn = DirtyNew;
        CPU_Req = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int lat, mreq, wr_pulses;
        logic [17:0] tags [4];
        logic [9:0]  idxs [4];
        logic [3:0]  bes  [10];
        tags = '{18'h00000, 18'h00001, 18'h2A5A5, 18'h3FFFF};
        idxs = '{10'h100, 10'h000, 10'h3FF, 10'h001};
        bes  = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                 4'b0101, 4'b0110, 4'b0000};
        for (int i = 0; i < 1024; i++) begin
            blk_valid[i] = 1'b0; blk_dirty[i] = 1'b0; blk_tag[i] = '0; blk_data[i] = '0;
            ref_valid[i] = 1'b0; ref_dirty[i] = 1'b0; ref_tag[i] = '0; ref_data[i] = '0;
        end

        repeat (3) @(negedge clk);
        check("rst_cpu_rdy",   {127'd0, CPU_Rdy}, 128'd0);
        check("rst_mem_req",   {127'd0, Mem_Req}, 128'd0);
        check("rst_mem_wr",    {127'd0, Mem_Wr},  128'd0);
        check("rst_wr",        {127'd0, Wr},      128'd0);
        check("rst_cpu_rdata", {96'd0, CPU_Rdata}, 128'd0);
        check("rst_mem_addr",  {96'd0, Mem_Addr},  128'd0);
        check("rst_mem_wdata", Mem_Wdata, 128'd0);
        rst_n = 1'b1;

        // cold read miss, then repeat hit
        cpu_op(1'b0, 32'h0000_1004, 4'hF, 32'd0, lat, mreq);
        check("cold_read_word", {96'd0, last_rdata}, {96'd0, 32'hBBBB_BBBB});
        cpu_op(1'b0, 32'h0000_1004, 4'hF, 32'd0, lat, mreq);
        check("hit_latency", 128'(lat), 128'd2);
        check("hit_no_mem_req", 128'(mreq), 128'd0);

        // half-word write hit
        cpu_op(1'b1, 32'h0000_1008, 4'b0011, 32'h1234_5678, lat, mreq);
        check("wh_wr", {127'd0, last_wr}, 128'd1);
        check("wh_en_word", {124'd0, last_ew}, 128'b0100);
        check("wh_dirtynew", {127'd0, last_dn}, 128'd1);
        @(negedge clk);
`ifdef CACHE_CTRL_STATS_EN
        check("stats_hit_a",  {96'd0, Hit_Cnt},  128'd2);
        check("stats_miss_a", {96'd0, Miss_Cnt}, 128'd1);
`endif

        // conflict miss forcing writeback of the dirty line
        cpu_op(1'b0, 32'h0000_5008, 4'hF, 32'd0, lat, mreq);
        @(negedge clk);
`ifdef CACHE_CTRL_STATS_EN
        check("stats_hit_b",  {96'd0, Hit_Cnt},  128'd2);
        check("stats_miss_b", {96'd0, Miss_Cnt}, 128'd2);
`endif
        // read back the written word through memory
        cpu_op(1'b0, 32'h0000_1008, 4'hF, 32'd0, lat, mreq);
        check("readback_word", {96'd0, last_rdata}, {96'd0, 32'hCCCC_5678});

        // randomized traffic over a few conflicting lines
        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            a = {tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 3)], 2'($urandom_range(0, 3)), 2'b00};
            cpu_op(1'($urandom_range(0, 1)), a, bes[$urandom_range(0, 9)], $urandom, lat, mreq);
        end
        @(negedge clk);
`ifdef CACHE_CTRL_STATS_EN
        check("stats_hit_rand",  {96'd0, Hit_Cnt},  128'(ref_hits));
        check("stats_miss_rand", {96'd0, Miss_Cnt}, 128'(ref_misses));
`endif

        // reset while a line fill is outstanding
        mem_hold = 1'b1;
        @(negedge clk);
        CPU_Req = 1'b1; CPU_Wr = 1'b0; CPU_Addr = 32'hAAAA_9550; CPU_Byte_En = 4'hF;
        for (int k = 0; k < 20 && !Mem_Req; k++) @(negedge clk);
        check("alloc_reached", {127'd0, Mem_Req}, 128'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_req", {127'd0, Mem_Req}, 128'd0);
        check("rst_mid_cpu_rdy", {127'd0, CPU_Rdy}, 128'd0);
        CPU_Req = 1'b0;
        mem_exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        mem_hold = 1'b0;
        ref_hits = 0;
        ref_misses = 0;
        wr_pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (Wr || Mem_Req) wr_pulses++;
        end
        check("rst_no_refill_wr", 128'(wr_pulses), 128'd0);

        // the abandoned address still works normally afterwards
        cpu_op(1'b0, 32'hAAAA_9550, 4'hF, 32'd0, lat, mreq);
        @(negedge clk);
`ifdef CACHE_CTRL_STATS_EN
        check("stats_after_rst_hit",  {96'd0, Hit_Cnt},  128'(ref_hits));
        check("stats_after_rst_miss", {96'd0, Miss_Cnt}, 128'(ref_misses));
`endif
        repeat (5) @(negedge clk);
        check("cpu_queue_drained", 128'(cpu_exp_q.size()), 128'd0);
        check("mem_queue_drained", 128'(mem_exp_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
